// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer
//   Upstream driver for a JK flip-flop. Commands (hold/clear/set/toggle plus a
//   repeat count) arrive over a valid/ready handshake and are queued in a small
//   FIFO. Each command is replayed as registered j/k levels for its repeat
//   count. The flip-flop output is then checked against the predicted value
//   for one cycle, and any difference is flagged and counted.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   cmd_valid  command offered
//   cmd_ready  FIFO has room (registered occupancy only)
//   cmd_op     00 hold, 01 clear, 10 set, 11 toggle
//   cmd_len    drive cycles, 0 treated as 1
//   j, k       registered drive to the flip-flop
//   q_in       flip-flop output fed back
//   busy       command in DRIVE or CHECK
//   done       one-cycle pulse in CHECK
//   mismatch   one-cycle pulse in CHECK when q_in differs from prediction
//   err_count  saturating mismatch counter
module jk_cmd_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             j,
   output logic             k,
   input  logic             q_in,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
   output logic [7:0]       err_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

   state_t           state, state_nxt;
   logic [LEN_W+1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             full, empty, push, pop;
   logic [1:0]       head_op;
   logic [LEN_W-1:0] head_len, head_cnt, cnt;
   logic             head_exp, exp_q;

   // ---------------- command FIFO ----------------
   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = !empty && ((state == IDLE) || (state == CHECK));

   assign {head_op, head_len} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_op, cmd_len};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------- prediction at pop time ----------------
   assign head_cnt = (head_len == '0) ? LEN_W'(1) : head_len;

   // Toggle parity depends only on the loaded count, so the expected value
   // can be fixed at pop from the q_in sampled on that same edge.
   always_comb begin
      head_exp = q_in;
      case (head_op)
         2'b00:   head_exp = q_in;
         2'b01:   head_exp = 1'b0;
         2'b10:   head_exp = 1'b1;
         default: head_exp = q_in ^ head_cnt[0];
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty) state_nxt = DRIVE;
         DRIVE:   if (cnt == LEN_W'(1)) state_nxt = CHECK;
         CHECK:   state_nxt = empty ? IDLE : DRIVE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         exp_q     <= 1'b0;
         j         <= 1'b0;
         k         <= 1'b0;
         err_count <= '0;
      end else begin
         if (pop) begin
            cnt   <= head_cnt;
            exp_q <= head_exp;
            j     <= head_op[1];
            k     <= head_op[0];
         end else if (state == DRIVE) begin
            if (cnt == LEN_W'(1)) begin
               j <= 1'b0;
               k <= 1'b0;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end else begin
            j <= 1'b0;
            k <= 1'b0;
         end
         if (mismatch && (err_count != '1)) err_count <= err_count + 1'b1;
      end
   end

   // CHECK lasts exactly one cycle, so the status pulses decode from state.
   assign busy     = (state == DRIVE) || (state == CHECK);
   assign done     = (state == CHECK);
   assign mismatch = done && (q_in != exp_q);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
module tb_jk_cmd_sequencer;

   logic       clk, reset;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_len;
   logic       j, k, q_in;
   logic       busy, done, mismatch;
   logic [7:0] err_count;

   int n_cmp = 0;
   int n_mis = 0;

   // flip-flop being driven, with a fault-injection override on its output
   logic ff_q;
   logic force_zero;

   jk_cmd_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len),
      .j(j), .k(k), .q_in(q_in),
      .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      if (!reset) ff_q <= 1'b0;
      else begin
         case ({j, k})
            2'b10:   ff_q <= 1'b1;
            2'b01:   ff_q <= 1'b0;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end
   assign q_in = force_zero ? 1'b0 : ff_q;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // presents one command and returns once the accepting edge has passed
   task automatic push(input logic [1:0] op, input logic [3:0] len, output bit ok);
      cmd_op = op; cmd_len = len; cmd_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin
            step();
            ok = 1'b1;
            break;
         end
         step();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 4'd0; force_zero = 1'b0;
      #2;
      n_cmp++;
      if ({j, k, busy, done, mismatch} !== 5'b0) begin
         n_mis++; $display("FAIL reset_outs: got %b, want 00000", {j, k, busy, done, mismatch});
      end
      n_cmp++;
      if (err_count !== 8'd0) begin
         n_mis++; $display("FAIL reset_err: got %0d, want 0", err_count);
      end
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      step();
      n_cmp++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_mis++; $display("FAIL reset_release: got ready=%b busy=%b, want ready=1 busy=0", cmd_ready, busy);
      end
   endtask

   task automatic test_set_len1();
      bit ok;
      push(2'b10, 4'd1, ok);
      n_cmp++;
      if (ok !== 1'b1 || j !== 1'b0) begin
         n_mis++; $display("FAIL set_push: got ok=%b j=%b, want ok=1 j=0", ok, j);
      end
      step();
      n_cmp++;
      if ({j, k, busy} !== 3'b101) begin
         n_mis++; $display("FAIL set_drive: got jk/busy=%b, want 101", {j, k, busy});
      end
      step();
      n_cmp++;
      if ({j, k, done, q_in, mismatch} !== 5'b00110) begin
         n_mis++; $display("FAIL set_check: got j,k,done,q,mis=%b, want 00110", {j, k, done, q_in, mismatch});
      end
      step();
      n_cmp++;
      if ({done, busy} !== 2'b00 || err_count !== 8'd0) begin
         n_mis++; $display("FAIL set_idle: got done/busy=%b err=%0d, want 00 err=0", {done, busy}, err_count);
      end
   endtask

   task automatic test_clear_len0();
      bit ok;
      push(2'b01, 4'd0, ok);
      step();
      n_cmp++;
      if (ok !== 1'b1 || {j, k} !== 2'b01) begin
         n_mis++; $display("FAIL clr0_drive: got ok=%b jk=%b, want ok=1 jk=01", ok, {j, k});
      end
      step();
      n_cmp++;
      if ({j, k, done, q_in, mismatch} !== 5'b00100) begin
         n_mis++; $display("FAIL clr0_check: got j,k,done,q,mis=%b, want 00100", {j, k, done, q_in, mismatch});
      end
      step();
   endtask

   task automatic test_toggle(input logic [3:0] len, input logic q0, input logic q1);
      bit ok;
      int bad = 0;
      n_cmp++;
      if (q_in !== q0) begin
         n_mis++; $display("FAIL tog%0d_start: got q=%b, want %b", len, q_in, q0);
      end
      push(2'b11, len, ok);
      for (int i = 0; i < int'(len); i++) begin
         step();
         if ({j, k, busy, done} !== 4'b1110) bad++;
      end
      n_cmp++;
      if (ok !== 1'b1 || bad != 0) begin
         n_mis++; $display("FAIL tog%0d_drive: got ok=%b bad_cycles=%0d, want ok=1 bad_cycles=0", len, ok, bad);
      end
      step();
      n_cmp++;
      if ({j, k, done, q_in, mismatch} !== {3'b001, q1, 1'b0}) begin
         n_mis++; $display("FAIL tog%0d_check: got j,k,done,q,mis=%b, want %b", len,
                           {j, k, done, q_in, mismatch}, {3'b001, q1, 1'b0});
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [1:0] ops  [5] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b11};
      logic [3:0] lens [5] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd0};
      logic [2:0] exp_tr [$];
      bit ok;
      bit all_ready = 1'b1;
      int stall = 0;
      for (int c = 0; c < 5; c++) begin
         int n = (lens[c] == 4'd0) ? 1 : int'(lens[c]);
         for (int i = 0; i < n; i++) exp_tr.push_back({ops[c], 1'b0});
         exp_tr.push_back(3'b001);
      end
      // long hold keeps the sequencer in DRIVE while the FIFO fills
      push(2'b00, 4'd15, ok);
      step();
      cmd_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cmd_op = ops[c]; cmd_len = lens[c];
         if (cmd_ready !== 1'b1) all_ready = 1'b0;
         step();
      end
      n_cmp++;
      if (ok !== 1'b1 || all_ready !== 1'b1 || cmd_ready !== 1'b0) begin
         n_mis++; $display("FAIL fill_full: got ok=%b accepted4=%b ready=%b, want 1 1 0", ok, all_ready, cmd_ready);
      end
      cmd_op = ops[4]; cmd_len = lens[4];
      while (cmd_ready !== 1'b1 && stall < 40) begin
         stall++;
         step();
      end
      n_cmp++;
      if (stall != 12) begin
         n_mis++; $display("FAIL fill_stall: got %0d cycles, want 12", stall);
      end
      for (int t = 0; t < 13; t++) begin
         n_cmp++;
         if ({j, k, done} !== exp_tr[t]) begin
            n_mis++; $display("FAIL b2b_trace[%0d]: got j,k,done=%b, want %b", t, {j, k, done}, exp_tr[t]);
         end
         step();
         cmd_valid = 1'b0;
      end
      n_cmp++;
      if (busy !== 1'b0 || err_count !== 8'd0) begin
         n_mis++; $display("FAIL b2b_end: got busy=%b err=%0d, want busy=0 err=0", busy, err_count);
      end
   endtask

   task automatic test_fault_saturate();
      bit ok;
      int missed = 0;
      int rejected = 0;
      force_zero = 1'b1;
      for (int n = 1; n <= 256; n++) begin
         push(2'b10, 4'd1, ok);
         if (!ok) rejected++;
         step();
         step();
         if ({done, mismatch} !== 2'b11) missed++;
         step();
         if (n == 1) begin
            n_cmp++;
            if (err_count !== 8'd1 || mismatch !== 1'b0) begin
               n_mis++; $display("FAIL fault_first: got err=%0d mis=%b, want err=1 mis=0", err_count, mismatch);
            end
         end
         if (n == 255) begin
            n_cmp++;
            if (err_count !== 8'd255) begin
               n_mis++; $display("FAIL fault_255: got %0d, want 255", err_count);
            end
         end
      end
      n_cmp++;
      if (err_count !== 8'd255) begin
         n_mis++; $display("FAIL fault_sat: got %0d, want 255", err_count);
      end
      n_cmp++;
      if (missed != 0 || rejected != 0) begin
         n_mis++; $display("FAIL fault_pulses: got missed=%0d rejected=%0d, want 0 0", missed, rejected);
      end
      force_zero = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok1, ok2, ok3;
      bit seen = 1'b0;
      push(2'b11, 4'd8, ok1);
      step();
      push(2'b01, 4'd1, ok2);
      push(2'b10, 4'd1, ok3);
      n_cmp++;
      if ({ok1, ok2, ok3} !== 3'b111 || {j, k, busy} !== 3'b111) begin
         n_mis++; $display("FAIL mid_pre: got ok=%b jk/busy=%b, want 111 111", {ok1, ok2, ok3}, {j, k, busy});
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({j, k, busy, done, mismatch} !== 5'b0 || err_count !== 8'd0) begin
         n_mis++; $display("FAIL mid_async: got outs=%b err=%0d, want 00000 err=0",
                           {j, k, busy, done, mismatch}, err_count);
      end
      @(negedge clk) reset = 1'b1;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_mis++; $display("FAIL mid_ready: got %b, want 1", cmd_ready);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         if (done || j || k || busy) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_mis++; $display("FAIL mid_discard: got activity=%b, want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_set_len1();
      test_clear_len0();
      test_toggle(4'd3, 1'b0, 1'b1);
      test_toggle(4'd4, 1'b1, 1'b1);
      test_back_to_back();
      test_fault_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
